// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Two-requester arbiter and sequencer in front of the 128K x 16 external SRAM
// controller. Port A is the Game Boy core cart-RAM path, port B is the
// save/load bridge. One requester is granted at a time. The granted access
// holds the controller bus for ACC_CYCLES cycles, captures read data, and
// returns a one-cycle acknowledge to the winner.
//
// Optional feature macro: SRAM_ARB_RR_EN
//   defined   : round-robin arbitration (port not granted last wins a tie;
//               the last-grant flag resets to B so A wins the first tie)
//   undefined : fixed priority, A always wins a tie
//
// Parameters:
//   ACC_CYCLES  cycles the controller bus is held per access (2..15)
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   a_req/b_req           request levels; command fields held while high
//   a_we/b_we             1 = write, 0 = read
//   a_ub,a_lb/b_ub,b_lb   byte enables (writes only)
//   a_addr/b_addr [16:0]  word address
//   a_d/b_d       [15:0]  write data
//   a_q/b_q       [15:0]  read data, updated only by that port's reads
//   a_ack/b_ack           one-cycle completion pulse
//   mem_we,mem_ub,mem_lb  controller write enable and byte enables
//   mem_addr      [16:0]  controller address
//   mem_d         [15:0]  controller write data
//   mem_q         [15:0]  controller registered read data
// All outputs are registered.
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ACC_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        a_req,
    input  logic        a_we,
    input  logic        a_ub,
    input  logic        a_lb,
    input  logic [16:0] a_addr,
    input  logic [15:0] a_d,
    output logic [15:0] a_q,
    output logic        a_ack,

    input  logic        b_req,
    input  logic        b_we,
    input  logic        b_ub,
    input  logic        b_lb,
    input  logic [16:0] b_addr,
    input  logic [15:0] b_d,
    output logic [15:0] b_q,
    output logic        b_ack,

    output logic        mem_we,
    output logic        mem_ub,
    output logic        mem_lb,
    output logic [16:0] mem_addr,
    output logic [15:0] mem_d,
    input  logic [15:0] mem_q
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_ACK    = 2'd2;

    localparam logic [3:0] CNT_LAST = 4'(ACC_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_selB;
    logic        r_memWe;
    logic        r_memUb;
    logic        r_memLb;
    logic [16:0] r_memAddr;
    logic [15:0] r_memD;
    logic [15:0] r_aQ;
    logic [15:0] r_bQ;
    logic        r_aAck;
    logic        r_bAck;

    logic        w_anyReq;
    logic        w_grantB;
    logic        w_winWe;
    logic        w_winUb;
    logic        w_winLb;
    logic [16:0] w_winAddr;
    logic [15:0] w_winD;
    logic        w_accessDone;

    assign w_anyReq = a_req | b_req;

`ifdef SRAM_ARB_RR_EN
    // Remembers which port won the last grant; a tie goes to the other one.
    logic r_lastB;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lastB <= 1'b1;
        end else if (r_state == S_IDLE && w_anyReq) begin
            r_lastB <= w_grantB;
        end
    end

    assign w_grantB = b_req & (~a_req | ~r_lastB);
`else
    assign w_grantB = b_req & ~a_req;
`endif

    // Winner's command fields. Reads force both byte enables on so the
    // controller returns the full word; the requester's enables gate writes.
    assign w_winWe   = w_grantB ? b_we   : a_we;
    assign w_winAddr = w_grantB ? b_addr : a_addr;
    assign w_winD    = w_grantB ? b_d    : a_d;
    assign w_winUb   = w_winWe ? (w_grantB ? b_ub : a_ub) : 1'b1;
    assign w_winLb   = w_winWe ? (w_grantB ? b_lb : a_lb) : 1'b1;

    assign w_accessDone = (r_state == S_ACCESS) && (r_cnt == CNT_LAST);

    // Sequencer: IDLE grants and latches the bus, ACCESS holds it for the
    // access window, ACK spends one cycle with the ack pulse before returning
    // to IDLE. Requests are not looked at outside IDLE, so anything raised
    // during ACCESS or ACK simply waits for the next IDLE evaluation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_selB    <= 1'b0;
            r_memWe   <= 1'b0;
            r_memUb   <= 1'b0;
            r_memLb   <= 1'b0;
            r_memAddr <= 17'd0;
            r_memD    <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_memWe <= 1'b0;
                    if (w_anyReq) begin
                        r_selB    <= w_grantB;
                        r_memWe   <= w_winWe;
                        r_memUb   <= w_winUb;
                        r_memLb   <= w_winLb;
                        r_memAddr <= w_winAddr;
                        r_memD    <= w_winD;
                        r_cnt     <= 4'd0;
                        r_state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_accessDone) begin
                        r_memWe <= 1'b0;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_memWe <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read data capture and acknowledge pulses. Only the granted port's q
    // register is ever written, and only when the finished access was a read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_aQ   <= 16'd0;
            r_bQ   <= 16'd0;
            r_aAck <= 1'b0;
            r_bAck <= 1'b0;
        end else begin
            r_aAck <= 1'b0;
            r_bAck <= 1'b0;
            if (w_accessDone) begin
                if (r_selB) begin
                    r_bAck <= 1'b1;
                    if (!r_memWe) begin
                        r_bQ <= mem_q;
                    end
                end else begin
                    r_aAck <= 1'b1;
                    if (!r_memWe) begin
                        r_aQ <= mem_q;
                    end
                end
            end
        end
    end

    assign a_q      = r_aQ;
    assign b_q      = r_bQ;
    assign a_ack    = r_aAck;
    assign b_ack    = r_bAck;
    assign mem_we   = r_memWe;
    assign mem_ub   = r_memUb;
    assign mem_lb   = r_memLb;
    assign mem_addr = r_memAddr;
    assign mem_d    = r_memD;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
//
// Directed bench for sram_arbiter with ACC_CYCLES = 3. A small controller
// model registers the address, then returns registered read data one cycle
// later, and applies byte-enabled writes. Its memory is preloaded with
// addr[15:0] ^ 16'hC3C3 so every expected read value is known in advance.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

    logic        clk;
    logic        reset_n;
    logic        a_req, a_we, a_ub, a_lb;
    logic [16:0] a_addr;
    logic [15:0] a_d;
    logic [15:0] a_q;
    logic        a_ack;
    logic        b_req, b_we, b_ub, b_lb;
    logic [16:0] b_addr;
    logic [15:0] b_d;
    logic [15:0] b_q;
    logic        b_ack;
    logic        mem_we, mem_ub, mem_lb;
    logic [16:0] mem_addr;
    logic [15:0] mem_d;
    logic [15:0] mem_q;

    int testCount;
    int failCount;
    logic [15:0] expAQ;
    logic [15:0] expBQ;

    sram_arbiter #(.ACC_CYCLES(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_ub(a_ub), .a_lb(a_lb),
        .a_addr(a_addr), .a_d(a_d), .a_q(a_q), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_ub(b_ub), .b_lb(b_lb),
        .b_addr(b_addr), .b_d(b_d), .b_q(b_q), .b_ack(b_ack),
        .mem_we(mem_we), .mem_ub(mem_ub), .mem_lb(mem_lb),
        .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model: address register, then read-data register.
    logic [15:0] sramArr [0:131071];
    logic [16:0] addrReg;

    initial begin
        for (int i = 0; i < 131072; i++) begin
            sramArr[i] = i[15:0] ^ 16'hC3C3;
        end
    end

    always @(posedge clk) begin
        addrReg <= mem_addr;
        mem_q   <= sramArr[addrReg];
        if (mem_we) begin
            if (mem_ub) sramArr[mem_addr][15:8] = mem_d[15:8];
            if (mem_lb) sramArr[mem_addr][7:0]  = mem_d[7:0];
        end
    end

    typedef struct {
        logic        port;
        logic        we;
        logic        ub;
        logic        lb;
        logic [16:0] addr;
        logic [15:0] d;
        logic        expUb;
        logic        expLb;
        logic [15:0] expQ;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int ackCycle;
        int ackCount;
        int otherAcks;
        ackCycle  = -1;
        ackCount  = 0;
        otherAcks = 0;
        @(negedge clk);
        if (v.port) begin
            b_we = v.we; b_ub = v.ub; b_lb = v.lb; b_addr = v.addr; b_d = v.d; b_req = 1'b1;
        end else begin
            a_we = v.we; a_ub = v.ub; a_lb = v.lb; a_addr = v.addr; a_d = v.d; a_req = 1'b1;
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checkOutput($sformatf("v%0d_mem_we", idx), 32'(mem_we), 32'(v.we));
                checkOutput($sformatf("v%0d_mem_addr", idx), 32'(mem_addr), 32'(v.addr));
                checkOutput($sformatf("v%0d_mem_ub", idx), 32'(mem_ub), 32'(v.expUb));
                checkOutput($sformatf("v%0d_mem_lb", idx), 32'(mem_lb), 32'(v.expLb));
                if (v.we) checkOutput($sformatf("v%0d_mem_d", idx), 32'(mem_d), 32'(v.d));
            end
            if ((v.port ? b_ack : a_ack) === 1'b1) begin
                ackCount++;
                if (ackCycle < 0) ackCycle = k;
                if (v.port) b_req = 1'b0; else a_req = 1'b0;
                if (!v.we) begin
                    checkOutput($sformatf("v%0d_q_at_ack", idx), 32'(v.port ? b_q : a_q), 32'(v.expQ));
                    if (v.port) expBQ = v.expQ; else expAQ = v.expQ;
                end
            end
            if ((v.port ? a_ack : b_ack) === 1'b1) otherAcks++;
        end
        checkOutput($sformatf("v%0d_ack_cycle", idx), 32'(ackCycle), 32'd4);
        checkOutput($sformatf("v%0d_ack_count", idx), 32'(ackCount), 32'd1);
        checkOutput($sformatf("v%0d_other_ack", idx), 32'(otherAcks), 32'd0);
        checkOutput($sformatf("v%0d_a_q_hold", idx), 32'(a_q), 32'(expAQ));
        checkOutput($sformatf("v%0d_b_q_hold", idx), 32'(b_q), 32'(expBQ));
    endtask

    initial begin
        int aCyc, bCyc, aCnt, bCnt;
        testCount = 0;
        failCount = 0;
        expAQ = 16'h0;
        expBQ = 16'h0;
        reset_n = 1'b0;
        a_req = 0; a_we = 0; a_ub = 0; a_lb = 0; a_addr = '0; a_d = '0;
        b_req = 0; b_we = 0; b_ub = 0; b_lb = 0; b_addr = '0; b_d = '0;

        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 17'h12345, 16'hBEEF, 1'b1, 1'b1, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 17'h12345, 16'h0000, 1'b1, 1'b1, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 17'h00100, 16'hA55A, 1'b1, 1'b0, 16'h0000};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 17'h00100, 16'h0000, 1'b1, 1'b1, 16'hA5C3};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 17'h1FFFF, 16'h1234, 1'b0, 1'b1, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 17'h1FFFF, 16'h0000, 1'b1, 1'b1, 16'h3C34};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 17'h00000, 16'h0000, 1'b1, 1'b1, 16'hC3C3};

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_ub", 32'(mem_ub), 32'd0);
        checkOutput("rst_mem_lb", 32'(mem_lb), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_d", 32'(mem_d), 32'd0);
        checkOutput("rst_a_q", 32'(a_q), 32'd0);
        checkOutput("rst_b_q", 32'(b_q), 32'd0);
        checkOutput("rst_a_ack", 32'(a_ack), 32'd0);
        checkOutput("rst_b_ack", 32'(b_ack), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Simultaneous reads: A wins, B follows five cycles later.
        a_we = 0; a_ub = 0; a_lb = 0; a_addr = 17'h00010; a_req = 1'b1;
        b_we = 0; b_ub = 0; b_lb = 0; b_addr = 17'h00020; b_req = 1'b1;
        aCyc = -1; bCyc = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (a_ack === 1'b1) begin
                if (aCyc < 0) aCyc = k;
                a_req = 1'b0;
                checkOutput("tie_a_q", 32'(a_q), 32'h0000C3D3);
            end
            if (b_ack === 1'b1) begin
                if (bCyc < 0) bCyc = k;
                b_req = 1'b0;
                checkOutput("tie_b_q", 32'(b_q), 32'h0000C3E3);
            end
        end
        checkOutput("tie_a_ack_cycle", 32'(aCyc), 32'd4);
        checkOutput("tie_b_ack_cycle", 32'(bCyc), 32'd9);
        expAQ = 16'hC3D3;
        expBQ = 16'hC3E3;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // B raised while A's write is in ACCESS; B reads what A wrote.
        @(negedge clk);
        a_we = 1; a_ub = 1; a_lb = 1; a_addr = 17'h00300; a_d = 16'h1111; a_req = 1'b1;
        aCyc = -1; bCyc = -1; aCnt = 0; bCnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                b_we = 0; b_ub = 0; b_lb = 0; b_addr = 17'h00300; b_req = 1'b1;
            end
            if (a_ack === 1'b1) begin
                aCnt++;
                if (aCyc < 0) aCyc = k;
                a_req = 1'b0;
            end
            if (b_ack === 1'b1) begin
                bCnt++;
                if (bCyc < 0) bCyc = k;
                b_req = 1'b0;
                checkOutput("late_b_q", 32'(b_q), 32'h00001111);
            end
        end
        checkOutput("late_a_ack_cycle", 32'(aCyc), 32'd4);
        checkOutput("late_b_ack_cycle", 32'(bCyc), 32'd9);
        checkOutput("late_a_ack_count", 32'(aCnt), 32'd1);
        checkOutput("late_b_ack_count", 32'(bCnt), 32'd1);
        checkOutput("late_a_q_hold", 32'(a_q), 32'(expAQ));

        // Reset one cycle into an A write, then re-grant after release.
        @(negedge clk);
        a_we = 1; a_ub = 1; a_lb = 1; a_addr = 17'h00400; a_d = 16'h7777; a_req = 1'b1;
        @(negedge clk);
        checkOutput("midrst_we_before", 32'(mem_we), 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("midrst_a_ack", 32'(a_ack), 32'd0);
        checkOutput("midrst_a_q", 32'(a_q), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        aCnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (a_ack === 1'b1) begin
                aCnt++;
                a_req = 1'b0;
            end
        end
        checkOutput("midrst_ack_count", 32'(aCnt), 32'd1);
        checkOutput("midrst_b_q", 32'(b_q), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
